// File: rtl/uart8_transmitter_if.sv
// Host-side transmit bus of the 8x-oversampled UART: byte strobe in, serial line and status out.
interface uart8_transmitter_if #(
   parameter int word_size = 8
);
   logic [word_size-1:0] XMT_data;
   logic                 Load_XMT;
   logic                 Serial_out;
   logic                 XMT_ready;
   logic                 XMT_busy;
   logic                 Frame_done;
   logic                 Overrun;

   modport master (
      output XMT_data, Load_XMT,
      input  Serial_out, XMT_ready, XMT_busy, Frame_done, Overrun
   );

   modport slave (
      input  XMT_data, Load_XMT,
      output Serial_out, XMT_ready, XMT_busy, Frame_done, Overrun
   );
endinterface

// File: rtl/uart8_transmitter.sv
// Double-buffered UART transmitter: 8N1 frames, each bit held Samples_per_bit clocks.
// Line falls one clock after a load into an idle holding register; a load into a full register is dropped and flagged.
module uart8_transmitter #(
   parameter int word_size       = 8,
   parameter int Samples_per_bit = 8,
   parameter int Num_sample_bits = 3,
   parameter int Num_bit_bits    = 4
) (
   input logic                Sample_clk,
   input logic                reset_,
   uart8_transmitter_if.slave xmt
);
   typedef enum logic {IDLE, SENDING} state_t;

   localparam int FRAME_BITS = word_size + 2;
   localparam logic [Num_sample_bits-1:0] SAMPLE_LAST = Num_sample_bits'(Samples_per_bit - 1);
   localparam logic [Num_bit_bits-1:0]    STOP_BIT    = Num_bit_bits'(word_size + 1);

   state_t                      state, state_nxt;
   logic                        hold_full, hold_full_nxt;
   logic [word_size-1:0]        hold_reg;
   logic [FRAME_BITS-1:0]       shift_reg, shift_nxt;
   logic [Num_sample_bits-1:0]  sample_cnt, sample_nxt;
   logic [Num_bit_bits-1:0]     bit_cnt, bit_nxt;
   logic                        busy_q, frame_done_q, overrun_q;

   logic frame_end;
   logic xfer;
   logic load_acc;

   // The holding register may take a new byte on the same edge it hands its old byte to the shifter.
   assign frame_end = (state == SENDING) && (sample_cnt == SAMPLE_LAST) && (bit_cnt == STOP_BIT);
   assign xfer      = hold_full && ((state == IDLE) || frame_end);
   assign load_acc  = xmt.Load_XMT && (!hold_full || xfer);

   always_comb begin
      state_nxt     = state;
      shift_nxt     = shift_reg;
      sample_nxt    = sample_cnt;
      bit_nxt       = bit_cnt;
      hold_full_nxt = xfer ? load_acc : (hold_full | load_acc);

      case (state)
         IDLE: begin
            if (xfer) begin
               shift_nxt  = {1'b1, hold_reg, 1'b0};
               sample_nxt = '0;
               bit_nxt    = '0;
               state_nxt  = SENDING;
            end
         end
         SENDING: begin
            if (sample_cnt == SAMPLE_LAST) begin
               sample_nxt = '0;
               shift_nxt  = {1'b1, shift_reg[FRAME_BITS-1:1]};
               bit_nxt    = bit_cnt + 1'b1;
               if (frame_end) begin
                  bit_nxt = '0;
                  if (xfer) begin
                     shift_nxt = {1'b1, hold_reg, 1'b0};
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end else begin
               sample_nxt = sample_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Sample_clk or negedge reset_) begin
      if (!reset_) begin
         state        <= IDLE;
         hold_full    <= 1'b0;
         hold_reg     <= '0;
         shift_reg    <= '1;
         sample_cnt   <= '0;
         bit_cnt      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state        <= state_nxt;
         hold_full    <= hold_full_nxt;
         if (load_acc) hold_reg <= xmt.XMT_data;
         shift_reg    <= shift_nxt;
         sample_cnt   <= sample_nxt;
         bit_cnt      <= bit_nxt;
         busy_q       <= (state_nxt == SENDING);
         frame_done_q <= frame_end;
         overrun_q    <= xmt.Load_XMT && !load_acc;
      end
   end

   // The shifter idles at all ones, so the line is a pure flop output in every state.
   assign xmt.Serial_out = shift_reg[0];
   assign xmt.XMT_ready  = ~hold_full;
   assign xmt.XMT_busy   = busy_q;
   assign xmt.Frame_done = frame_done_q;
   assign xmt.Overrun    = overrun_q;
endmodule

// File: tb/tb_uart8_transmitter.sv
// Bench for uart8_transmitter: frame-timeline reference model plus an 8x-oversampling receiver for loopback.
module tb_uart8_transmitter;
   localparam int FRAME = 80;
   localparam int MAXN  = 1600;

   logic Sample_clk = 1'b0;
   logic reset_;

   uart8_transmitter_if bus ();

   uart8_transmitter dut (
      .Sample_clk (Sample_clk),
      .reset_     (reset_),
      .xmt        (bus)
   );

   always #5 Sample_clk = ~Sample_clk;

   int n_chk = 0;
   int n_err = 0;

   bit          sl  [MAXN];
   logic [7:0]  sd  [MAXN];
   logic [4:0]  obs [MAXN];
   int          fs_q[$];
   logic [7:0]  fb_q[$];

   bit          rx_en = 1'b0;
   int          rx_phase = -1;
   logic [7:0]  rx_sh = 8'h00;
   logic [7:0]  rx_q[$];
   int          rx_ferr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Line level t clocks into a frame carrying byte b: start, 8 data LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int t);
      int k;
      k = t / 8;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic clear_sched();
      for (int i = 0; i < MAXN; i++) begin
         sl[i] = 1'b0;
         sd[i] = 8'h00;
      end
   endtask

   // Drive the load schedule for n edges, then replay it through a frame-timeline model.
   task automatic run_window(input int n, input string tag);
      bit         hv;
      logic [7:0] hb;
      int         cur_end;
      bit         acc, ln, bz, fd, ov;
      logic [4:0] want;
      hv = 1'b0; hb = 8'h00; cur_end = 0;
      fs_q.delete();
      fb_q.delete();
      for (int i = 0; i < n; i++) begin
         bus.Load_XMT = sl[i];
         bus.XMT_data = sl[i] ? sd[i] : 8'($urandom);
         @(posedge Sample_clk);
         #1;
         obs[i] = {bus.Serial_out, bus.XMT_busy, bus.Frame_done, bus.Overrun, bus.XMT_ready};
      end
      bus.Load_XMT = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (hv && i >= cur_end) begin
            fs_q.push_back(i);
            fb_q.push_back(hb);
            cur_end = i + FRAME;
            hv = 1'b0;
         end
         acc = sl[i] && !hv;
         ov  = sl[i] && !acc;
         if (acc) begin
            hv = 1'b1;
            hb = sd[i];
         end
         ln = 1'b1; bz = 1'b0; fd = 1'b0;
         foreach (fs_q[f]) begin
            if (i >= fs_q[f] && i < fs_q[f] + FRAME) begin
               bz = 1'b1;
               ln = frame_bit(fb_q[f], i - fs_q[f]);
            end
            if (i == fs_q[f] + FRAME) fd = 1'b1;
         end
         want = {ln, bz, fd, ov, !hv};
         chk($sformatf("%s c%0d line/busy/done/ovr/rdy", tag, i), 32'(obs[i]), 32'(want));
      end
   endtask

   // Receiver: find the start edge, sample mid-bit every 8 clocks, verify start and stop levels.
   initial begin
      int k;
      forever begin
         @(negedge Sample_clk);
         if (rx_en) begin
            if (rx_phase < 0) begin
               if (bus.Serial_out == 1'b0) rx_phase = 0;
            end else begin
               rx_phase++;
            end
            if (rx_phase >= 0 && rx_phase % 8 == 4) begin
               k = rx_phase / 8;
               if (k == 0) begin
                  if (bus.Serial_out !== 1'b0) begin
                     rx_ferr++;
                     rx_phase = -1;
                  end
               end else if (k <= 8) begin
                  rx_sh[k-1] = bus.Serial_out;
               end else begin
                  if (bus.Serial_out !== 1'b1) rx_ferr++;
                  else rx_q.push_back(rx_sh);
                  rx_phase = -1;
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] lb [16];
      int         ld;
      reset_       = 1'b0;
      bus.Load_XMT = 1'b0;
      bus.XMT_data = 8'h00;
      #12;
      chk("reset line",  32'(bus.Serial_out), 32'd1);
      chk("reset busy",  32'(bus.XMT_busy),   32'd0);
      chk("reset done",  32'(bus.Frame_done), 32'd0);
      chk("reset ovr",   32'(bus.Overrun),    32'd0);
      chk("reset ready", 32'(bus.XMT_ready),  32'd1);
      #4 reset_ = 1'b1;
      @(posedge Sample_clk);
      #1;

      clear_sched();
      sl[0] = 1'b1; sd[0] = 8'hB5;
      run_window(90, "single_b5");

      clear_sched();
      sl[0]  = 1'b1; sd[0]  = 8'h55;
      sl[20] = 1'b1; sd[20] = 8'hA3;
      run_window(175, "b2b_55_a3");

      clear_sched();
      sl[0] = 1'b1; sd[0] = 8'h01;
      sl[1] = 1'b1; sd[1] = 8'h02;
      sl[2] = 1'b1; sd[2] = 8'h03;
      run_window(175, "overrun_03");

      clear_sched();
      sl[0] = 1'b1; sd[0] = 8'hFF;
      sl[1] = 1'b1; sd[1] = 8'hFF;
      sl[2] = 1'b1; sd[2] = 8'hFF;
      run_window(175, "held_load_ff");

      // Reset in the middle of data bit 4 of 0xE6 (bit value 0) with 0x5A queued behind it.
      bus.Load_XMT = 1'b1; bus.XMT_data = 8'hE6;
      @(posedge Sample_clk); #1;
      bus.Load_XMT = 1'b0;
      @(posedge Sample_clk); #1;
      bus.Load_XMT = 1'b1; bus.XMT_data = 8'h5A;
      @(posedge Sample_clk); #1;
      bus.Load_XMT = 1'b0;
      repeat (42) begin
         @(posedge Sample_clk); #1;
      end
      chk("pre_rst line",  32'(bus.Serial_out), 32'd0);
      chk("pre_rst busy",  32'(bus.XMT_busy),   32'd1);
      chk("pre_rst ready", 32'(bus.XMT_ready),  32'd0);
      #3 reset_ = 1'b0;
      #1;
      chk("async_rst line",  32'(bus.Serial_out), 32'd1);
      chk("async_rst busy",  32'(bus.XMT_busy),   32'd0);
      chk("async_rst ready", 32'(bus.XMT_ready),  32'd1);
      chk("async_rst done",  32'(bus.Frame_done), 32'd0);
      chk("async_rst ovr",   32'(bus.Overrun),    32'd0);
      #2 reset_ = 1'b1;
      @(posedge Sample_clk); #1;

      clear_sched();
      sl[0] = 1'b1; sd[0] = 8'h3C;
      run_window(90, "after_rst_3c");

      // Sixteen random bytes, each queued during the previous frame, with occasional rejected extra loads.
      clear_sched();
      for (int j = 0; j < 16; j++) lb[j] = 8'($urandom);
      sl[0] = 1'b1; sd[0] = lb[0];
      for (int j = 1; j < 16; j++) begin
         ld = FRAME * (j - 1) + 1 + int'($urandom_range(0, 70));
         sl[ld] = 1'b1; sd[ld] = lb[j];
         if ($urandom_range(0, 1) == 1) begin
            sl[ld+1] = 1'b1; sd[ld+1] = 8'($urandom);
         end
      end
      rx_q.delete();
      rx_ferr  = 0;
      rx_phase = -1;
      rx_en    = 1'b1;
      run_window(1300, "loopback");
      rx_en = 1'b0;
      chk("rx count",   32'(rx_q.size()), 32'd16);
      chk("rx framing", 32'(rx_ferr),     32'd0);
      for (int j = 0; j < 16; j++) begin
         if (j < rx_q.size()) chk($sformatf("rx byte %0d", j), 32'(rx_q[j]), 32'(lb[j]));
         else                 chk($sformatf("rx byte %0d missing", j), 32'hFFFF_FFFF, 32'(lb[j]));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
